// File: rtl/sigma_bus_tracer.sv
// Passive trace recorder for one MemSplit32 link with a host register port for readback/control.
// Define SIGMA_TRACER_TIMESTAMP_EN to add a 32-bit cycle timestamp word (W4 at 0x18) to every record.
`ifndef TRACER_CAP
`define TRACER_CAP 256
`endif

module sigma_bus_tracer #(
    parameter int CAP   = `TRACER_CAP,
    parameter int PTR_W = $clog2(CAP)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mon_req,
    input  logic        mon_ack,
    input  logic        mon_we,
    input  logic        mon_resp,
    input  logic [31:0] mon_addr,
    input  logic [31:0] mon_wdata,
    input  logic [31:0] mon_rdata,
    input  logic [3:0]  mon_be,
    input  logic        host_req,
    output logic        host_ack,
    input  logic [31:0] host_addr,
    input  logic        host_we,
    input  logic [31:0] host_wdata,
    input  logic [3:0]  host_be,
    output logic        host_resp,
    output logic [31:0] host_rdata
);
    localparam int CNT_W           = PTR_W + 1;
    localparam int TRACE_FLUSH_BIT = 0;
    localparam int TRACE_EN_BIT    = 1;

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_STATUS = 3'd1;
    localparam logic [2:0] IDX_W0     = 3'd2;
    localparam logic [2:0] IDX_W1     = 3'd3;
    localparam logic [2:0] IDX_W2     = 3'd4;
    localparam logic [2:0] IDX_W3     = 3'd5;
    localparam logic [2:0] IDX_W4     = 3'd6;
`ifdef SIGMA_TRACER_TIMESTAMP_EN
    localparam logic [2:0] IDX_POP    = IDX_W4;
`else
    localparam logic [2:0] IDX_POP    = IDX_W3;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             enable_q, enable_d;
    logic             host_resp_q;
    logic [31:0]      host_rdata_q, rdata_d;

    logic [7:0]  mem_w0 [CAP];
    logic [31:0] mem_w1 [CAP];
    logic [31:0] mem_w2 [CAP];
    logic [31:0] mem_w3 [CAP];

    logic        req_ev, resp_ev, event_v;
    logic        full, empty;
    logic        rd_acc, wr_acc, ctrl_wr, flush, pop, push;
    logic [2:0]  idx;
    logic [7:0]  rec_w0;
    logic [31:0] rec_w1, rec_w2, rec_w3;

    // Byte enables and undecoded address/data bits have no function here.
    logic unused_host;
    assign unused_host = ^{host_be, host_addr[31:5], host_addr[1:0], host_wdata[31:2]};

`ifdef SIGMA_TRACER_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] mem_w4 [CAP];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= '0;
        else         ts_q <= ts_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_w4[wr_ptr_q] <= ts_q;
    end
`endif

    assign idx      = host_addr[4:2];
    assign host_ack = host_req;
    assign rd_acc   = host_req & ~host_we;
    assign wr_acc   = host_req & host_we;
    assign ctrl_wr  = wr_acc & (idx == IDX_CTRL);
    assign flush    = ctrl_wr & host_wdata[TRACE_FLUSH_BIT];

    assign req_ev   = mon_req & mon_ack;
    assign resp_ev  = mon_resp;
    assign event_v  = enable_q & (req_ev | resp_ev);

    assign full     = (count_q == CNT_W'(CAP));
    assign empty    = (count_q == '0);
    assign pop      = rd_acc & (idx == IDX_POP) & ~empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
    assign push     = event_v & ~flush & (~full | pop);

    assign rec_w0 = {req_ev ? mon_be : 4'h0, 1'b0, resp_ev, req_ev & mon_we, req_ev};
    assign rec_w1 = req_ev  ? mon_addr  : 32'h0;
    assign rec_w2 = req_ev  ? mon_wdata : 32'h0;
    assign rec_w3 = resp_ev ? mon_rdata : 32'h0;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_w0[wr_ptr_q] <= rec_w0;
            mem_w1[wr_ptr_q] <= rec_w1;
            mem_w2[wr_ptr_q] <= rec_w2;
            mem_w3[wr_ptr_q] <= rec_w3;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        enable_d   = enable_q;
        if (ctrl_wr) enable_d = host_wdata[TRACE_EN_BIT];
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (event_v && full && !pop) overflow_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (idx)
            IDX_CTRL:   rdata_d[TRACE_EN_BIT] = enable_q;
            IDX_STATUS: begin
                rdata_d[CNT_W-1:0] = count_q;
                rdata_d[16]        = full;
                rdata_d[17]        = empty;
                rdata_d[31]        = overflow_q;
            end
            IDX_W0:     if (!empty) rdata_d = {24'h0, mem_w0[rd_ptr_q]};
            IDX_W1:     if (!empty) rdata_d = mem_w1[rd_ptr_q];
            IDX_W2:     if (!empty) rdata_d = mem_w2[rd_ptr_q];
            IDX_W3:     if (!empty) rdata_d = mem_w3[rd_ptr_q];
`ifdef SIGMA_TRACER_TIMESTAMP_EN
            IDX_W4:     if (!empty) rdata_d = mem_w4[rd_ptr_q];
`endif
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            enable_q     <= 1'b0;
            host_resp_q  <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            enable_q    <= enable_d;
            host_resp_q <= rd_acc;
            if (rd_acc) host_rdata_q <= rdata_d;
        end
    end

    assign host_resp  = host_resp_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: doc/sigma_bus_tracer.md
Name: sigma_bus_tracer

Overview:
- Passive trace recorder attached to one MemSplit32 link (e.g. CPU data port to sigma_tile interconnect).
- Inputs are Monitor-modport signals only; the block never drives the observed link.
- Each cycle with a bus event writes one trace record into a circular buffer.
- Host software reads back records and controls the tracer through a separate MemSplit32 slave register port.

Parameters:
- CAP, 256, buffer depth in records; power of two, >= 4; defaults to TRACER_CAP.
- PTR_W, $clog2(CAP), pointer width; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mon_req, mon_ack, mon_we, mon_resp  in  1  observed MemSplit32 control signals.
- mon_addr, mon_wdata, mon_rdata  in  32  observed MemSplit32 address/data.
- mon_be  in  4  observed byte enables.
- host_req  in  1  register-port request.
- host_ack  out  1  register-port accept.
- host_addr  in  32  register address; bits [4:2] decoded.
- host_we  in  1  register write.
- host_wdata  in  32  register write data.
- host_be  in  4  ignored; full-word access only.
- host_resp  out  1  read response valid.
- host_rdata  out  32  read data.

Behaviour:
- Reset: host_resp=0, host_rdata=0, wr_ptr=rd_ptr=0, count=0, overflow=0, enable=0. Buffer contents are not reset.
- Event definitions:
  - req event: mon_req & mon_ack.
  - resp event: mon_resp.
  - Event cycle: enable=1 and (req event | resp event).
- Record format (one per event cycle, 4 words):
  - W0: bit0 req_v, bit1 we, bit2 resp_v, bits[7:4] be.
  - W1: addr. W2: wdata. W3: rdata.
  - Fields of an absent event are written as 0. A req and a resp in the same cycle share one record.
- Push on event cycle:
  - Not full: mem[wr_ptr] <= record; wr_ptr+1 wraps mod CAP; count+1.
  - Full (count==CAP): record dropped, overflow<=1 (sticky), pointers unchanged.
- host_ack = host_req (always ready, combinational).
- Accepted read: host_resp=1 exactly one cycle later with registered host_rdata.
- Accepted write: no response.
- Register map (byte offset):
  - 0x00 CTRL. Write: bit TRACE_FLUSH_BIT(0)=1 flushes; bit TRACE_EN_BIT(1) sets enable. Read: {30'b0, enable, 1'b0}.
  - 0x04 STATUS, RO: [PTR_W:0] count, bit16 full, bit17 empty, bit31 overflow.
  - 0x08..0x14: W0..W3 of the head record mem[rd_ptr].
  - Reading 0x14 pops: rd_ptr+1 wraps, count-1.
  - Read when empty returns 0 and does not pop.
  - Writes to 0x04..0x14 are ignored. Unmapped offsets read 0.
- Push and pop in the same cycle: both pointers advance, count unchanged.
  - Full + pop + event: push is accepted, no overflow.
  - Empty + event + pop: pop ignored, push proceeds.
- Flush: next cycle wr_ptr=rd_ptr=count=overflow=0.
  - An event in the flush cycle is dropped, with no overflow.
  - A flush write takes priority over a pop in the same cycle (not possible from a single port; stated for completeness).
- enable takes effect the cycle after the CTRL write. Events in the write cycle use the old enable.
- host_rdata is sampled from registers in the accept cycle, i.e. before that cycle's push/pop/flush updates.
- Reset asserted mid-operation clears state immediately. A pending host_resp is lost.

Optional Feature:
- Macro SIGMA_TRACER_TIMESTAMP_EN.
- Defined:
  - 32-bit free-running cycle counter, reset to 0, wraps.
  - Each record gains W4 = counter value at the event cycle.
  - W4 readable at 0x18. The pop moves from 0x14 to 0x18; 0x14 becomes a plain read.
- Undefined: no counter or W4 storage; 0x18 reads 0; pop on 0x14.

Test Plan:
- Reset, enable=0, 10 bus writes -> STATUS count=0, empty=1; host reads of 0x08..0x14 return 0 with host_resp exactly 1 cycle after accept.
- Enable, bus write addr=0x1000 wdata=0xDEADBEEF be=0xF, then bus read addr=0x2000 resp rdata=0x12345678 two cycles later -> 3 records: W0=0xF3/W1=0x1000/W2=0xDEADBEEF; W0=0x01/W1=0x2000; W0=0x04/W3=0x12345678; count reaches 0 after three 0x14 reads.
- Same-cycle req event and resp -> single record with W0 bits 0 and 2 set, count +1.
- CAP+5 event cycles without pops -> count=CAP, full=1, overflow=1; first CAP records retained in order; a subsequent pop plus event in the same cycle keeps count=CAP.
- Full buffer, write CTRL=0x3 -> next cycle count=0, empty=1, overflow=0, enable=1; the next event is stored at index 0.
- With SIGMA_TRACER_TIMESTAMP_EN: events at cycles 100 and 107 after reset -> W4 values differ by 7; the 0x18 read pops, the 0x14 read does not.
